// File: rtl/cpu_core_param_pkg.sv
// Shared definitions for the parametrised multicycle core: FSM states,
// flag bit positions, opcode numbering and operand-usage decode helpers.
package cpu_core_param_pkg;

  typedef enum logic [2:0] {F_OP, F_P1, F_P2, EXEC, MEM, FAULT} state_e;

  localparam int unsigned FLAG_CF = 0;
  localparam int unsigned FLAG_ZF = 1;
  localparam int unsigned FLAG_OF = 2;

  localparam logic [7:0] OP_NOP  = 8'h00, OP_SCF  = 8'h01, OP_CCF  = 8'h02, OP_COF = 8'h03;
  localparam logic [7:0] OP_CZF  = 8'h04, OP_MOV1 = 8'h05, OP_MOV2 = 8'h06, OP_MOV3 = 8'h07;
  localparam logic [7:0] OP_MOV4 = 8'h08, OP_POP  = 8'h09, OP_OUT  = 8'h0A, OP_PUSH = 8'h0B;
  localparam logic [7:0] OP_ADD  = 8'h0C, OP_ADC  = 8'h0D, OP_SUB  = 8'h0E, OP_SUC  = 8'h0F;
  localparam logic [7:0] OP_CMP  = 8'h14, OP_AND  = 8'h15, OP_NEG  = 8'h16, OP_NOT  = 8'h17;
  localparam logic [7:0] OP_OR   = 8'h18, OP_SHL  = 8'h19, OP_SHR  = 8'h1A, OP_XOR  = 8'h1B;
  localparam logic [7:0] OP_TEST = 8'h1C, OP_CALL = 8'h1E, OP_RET  = 8'h1F, OP_JMP  = 8'h20;
  localparam logic [7:0] OP_JC   = 8'h21, OP_JNC  = 8'h22, OP_JZ   = 8'h23, OP_JNZ  = 8'h24;
  localparam logic [7:0] OP_JO   = 8'h25, OP_JNO  = 8'h26, OP_IN   = 8'h28, OP_XCH  = 8'h29;

  // par1 names a register (as opposed to an address or immediate)
  function automatic logic uses_p1_reg(input logic [7:0] op);
    case (op)
      OP_MOV1, OP_MOV2, OP_MOV3, OP_POP, OP_PUSH, OP_IN, OP_XCH,
      OP_ADD, OP_ADC, OP_SUB, OP_SUC, OP_CMP, OP_AND, OP_OR, OP_XOR,
      OP_TEST, OP_NOT, OP_NEG, OP_SHL, OP_SHR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_p2_reg(input logic [7:0] op);
    case (op)
      OP_MOV1, OP_MOV4, OP_OUT, OP_XCH,
      OP_ADD, OP_ADC, OP_SUB, OP_SUC, OP_CMP,
      OP_AND, OP_OR, OP_XOR, OP_TEST: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_core_param_if.sv
// Memory bus between the core (master) and program/data memory (slave).
interface cpu_core_param_if #(parameter int unsigned WIDTH = 16) ();
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cpu_core_param_alu.sv
// Combinational ALU: arithmetic with carry/borrow and signed overflow,
// bitwise logic, negate and single-bit shifts.
module cpu_alu_param
  import cpu_core_param_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cf_in,
  output logic [WIDTH-1:0] y,
  output logic             cf,
  output logic             zf,
  output logic             of
);
  logic [WIDTH:0] wide;
  logic           cin;

  always_comb begin
    wide = '0;
    y    = '0;
    cf   = 1'b0;
    of   = 1'b0;
    cin  = cf_in & ((op == OP_ADC) | (op == OP_SUC));
    case (op)
      OP_ADD, OP_ADC: begin
        wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        y    = wide[WIDTH-1:0];
        cf   = wide[WIDTH];
        of   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SUC, OP_CMP: begin
        // bit WIDTH of the extended difference is the borrow
        wide = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        y    = wide[WIDTH-1:0];
        cf   = wide[WIDTH];
        of   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND, OP_TEST: y = a & b;
      OP_OR:           y = a | b;
      OP_XOR:          y = a ^ b;
      OP_NOT:          y = ~a;
      OP_NEG: begin
        y  = '0 - a;
        cf = |a;
        of = a[WIDTH-1] & y[WIDTH-1];
      end
      OP_SHL: begin
        y  = {a[WIDTH-2:0], 1'b0};
        cf = a[WIDTH-1];
      end
      OP_SHR: begin
        y  = {1'b0, a[WIDTH-1:1]};
        cf = a[0];
      end
      default: y = '0;
    endcase
    zf = (y == '0);
  end
endmodule

// File: rtl/cpu_core_param.sv
// Parametrised multicycle core: 3-word fetch over a req/ack bus, register
// file, bounded hardware stack, IO port and an absorbing FAULT state.
module cpu_core_param
  import cpu_core_param_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      NREG        = 4,
  parameter int unsigned      STACK_DEPTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_core_param_if.master    bus,
  input  logic [WIDTH-1:0]    in,
  output logic [WIDTH-1:0]    base,
  output logic [WIDTH-1:0]    data,
  output logic                out_valid,
  output logic                halted
);
  localparam int unsigned RW  = $clog2(NREG);
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_e           state, state_d;
  logic [WIDTH-1:0] pc, pc_d, opw, p1, p2;
  logic [WIDTH-1:0] regs   [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] stack  [STACK_DEPTH];
  logic [SPW-1:0]   sp, sp_d;
  logic [2:0]       flags, flags_d;
  logic             req_d, bad, stk_we, out_we;
  logic [WIDTH-1:0] stk_wdata;

  logic [7:0]       op;
  logic             ack, op_ok, f1_ok, f2_ok, stk_full, stk_empty;
  logic [RW-1:0]    i1, i2;
  logic [WIDTH-1:0] r1, r2, stk_top;
  logic [SIW-1:0]   wr_idx, top_idx;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cf, alu_zf, alu_of;

  assign op        = opw[7:0];
  assign op_ok     = (opw >> 8) == '0;
  assign i1        = p1[RW-1:0];
  assign i2        = p2[RW-1:0];
  assign f1_ok     = (p1 >> RW) == '0;
  assign f2_ok     = (p2 >> RW) == '0;
  assign r1        = regs[i1];
  assign r2        = regs[i2];
  assign ack       = bus.mem_req & bus.mem_ack;
  assign stk_full  = (sp == SPW'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign wr_idx    = SIW'(sp);
  assign top_idx   = SIW'(sp - SPW'(1));
  assign stk_top   = stack[top_idx];
  assign halted    = (state == FAULT);

  cpu_alu_param #(.WIDTH(WIDTH)) u_alu (
    .op   (op),
    .a    (r1),
    .b    (r2),
    .cf_in(flags[FLAG_CF]),
    .y    (alu_y),
    .cf   (alu_cf),
    .zf   (alu_zf),
    .of   (alu_of)
  );

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    sp_d      = sp;
    flags_d   = flags;
    regs_d    = regs;
    bad       = 1'b0;
    stk_we    = 1'b0;
    stk_wdata = r1;
    out_we    = 1'b0;
    case (state)
      F_OP: if (ack) state_d = F_P1;
      F_P1: if (ack) state_d = F_P2;
      F_P2: if (ack) state_d = EXEC;
      MEM: if (ack) begin
        if (op == OP_MOV3) regs_d[i1] = bus.mem_rdata;
        state_d = F_OP;
      end
      EXEC: begin
        state_d = F_OP;
        pc_d    = pc + WIDTH'(3);
        bad     = !op_ok || (uses_p1_reg(op) && !f1_ok) || (uses_p2_reg(op) && !f2_ok);
        case (op)
          OP_NOP: ;
          OP_SCF: flags_d[FLAG_CF] = 1'b1;
          OP_CCF: flags_d[FLAG_CF] = 1'b0;
          OP_COF: flags_d[FLAG_OF] = 1'b0;
          OP_CZF: flags_d[FLAG_ZF] = 1'b0;
          OP_MOV1: regs_d[i1] = r2;
          OP_MOV2: regs_d[i1] = p2;
          OP_MOV3, OP_MOV4: state_d = MEM;
          OP_IN:  regs_d[i1] = in;
          OP_OUT: out_we = 1'b1;
          OP_XCH: begin
            regs_d[i1] = r2;
            regs_d[i2] = r1;
          end
          OP_PUSH: if (stk_full) bad = 1'b1;
            else begin
              stk_we = 1'b1;
              sp_d   = sp + SPW'(1);
            end
          OP_POP: if (stk_empty) bad = 1'b1;
            else begin
              regs_d[i1] = stk_top;
              sp_d       = sp - SPW'(1);
            end
          OP_ADD, OP_ADC, OP_SUB, OP_SUC, OP_AND, OP_OR, OP_XOR,
          OP_NOT, OP_NEG, OP_SHL, OP_SHR, OP_CMP, OP_TEST: begin
            if (op != OP_CMP && op != OP_TEST) regs_d[i1] = alu_y;
            flags_d[FLAG_CF] = alu_cf;
            flags_d[FLAG_ZF] = alu_zf;
            flags_d[FLAG_OF] = alu_of;
          end
          OP_JMP: pc_d = p1;
          OP_JC:  if (flags[FLAG_CF])  pc_d = p1;
          OP_JNC: if (!flags[FLAG_CF]) pc_d = p1;
          OP_JZ:  if (flags[FLAG_ZF])  pc_d = p1;
          OP_JNZ: if (!flags[FLAG_ZF]) pc_d = p1;
          OP_JO:  if (flags[FLAG_OF])  pc_d = p1;
          OP_JNO: if (!flags[FLAG_OF]) pc_d = p1;
          OP_CALL: if (stk_full) bad = 1'b1;
            else begin
              stk_we    = 1'b1;
              stk_wdata = pc + WIDTH'(3);
              sp_d      = sp + SPW'(1);
              pc_d      = p1;
            end
          OP_RET: if (stk_empty) bad = 1'b1;
            else begin
              pc_d = stk_top;
              sp_d = sp - SPW'(1);
            end
          default: bad = 1'b1;
        endcase
        // a faulting instruction leaves every architectural register untouched
        if (bad) begin
          state_d = FAULT;
          pc_d    = pc;
          sp_d    = sp;
          flags_d = flags;
          regs_d  = regs;
          stk_we  = 1'b0;
          out_we  = 1'b0;
        end
      end
      FAULT: ;
      default: state_d = FAULT;
    endcase
    req_d = (state_d == F_OP) || (state_d == F_P1) || (state_d == F_P2) || (state_d == MEM);
  end

  always_comb begin
    bus.mem_addr  = pc;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = r2;
    case (state)
      F_P1: bus.mem_addr = pc + WIDTH'(1);
      F_P2: bus.mem_addr = pc + WIDTH'(2);
      MEM: begin
        bus.mem_we   = (op == OP_MOV4);
        bus.mem_addr = (op == OP_MOV4) ? p1 : p2;
      end
      default: bus.mem_addr = pc;
    endcase
  end

  // mem_req is registered so reset drops it in the very next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= F_OP;
      pc          <= RESET_PC;
      sp          <= '0;
      flags       <= '0;
      bus.mem_req <= 1'b0;
      out_valid   <= 1'b0;
      base        <= '0;
      data        <= '0;
      opw         <= '0;
      p1          <= '0;
      p2          <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      sp          <= sp_d;
      flags       <= flags_d;
      regs        <= regs_d;
      bus.mem_req <= req_d;
      out_valid   <= out_we;
      if (out_we) begin
        base <= p1;
        data <= r2;
      end
      if (ack) begin
        case (state)
          F_OP:    opw <= bus.mem_rdata;
          F_P1:    p1  <= bus.mem_rdata;
          F_P2:    p2  <= bus.mem_rdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && stk_we) stack[wr_idx] <= stk_wdata;
  end
endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench for cpu_core_param: ALU vector table plus hand-written
// sequences for bus latency, branches, stack limits, IO and reset.
module tb_cpu_core_param;
  import cpu_core_param_pkg::*;

  localparam int unsigned W = 16;
  localparam logic [15:0] NOP = 16'h00, SCF = 16'h01, CCF = 16'h02, MOV1 = 16'h05, MOV2 = 16'h06;
  localparam logic [15:0] MOV3 = 16'h07, MOV4 = 16'h08, POP = 16'h09, OUT = 16'h0A, PUSH = 16'h0B;
  localparam logic [15:0] CMP = 16'h14, CALL = 16'h1E, RET = 16'h1F, JMP = 16'h20, JC = 16'h21;
  localparam logic [15:0] JZ = 16'h23, JNZ = 16'h24, IN = 16'h28, XCH = 16'h29;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] base, data;
  logic         out_valid, halted;

  cpu_core_param_if #(.WIDTH(W)) bus ();

  cpu_core_param #(.WIDTH(W), .NREG(4), .STACK_DEPTH(16), .RESET_PC(16'h0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .in       (in_port),
    .base     (base),
    .data     (data),
    .out_valid(out_valid),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  int          lat = 1;
  int          wcnt = 0;
  logic        force_ack = 1'b0;
  int          ov_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  assign bus.mem_ack   = force_ack || (bus.mem_req && (wcnt == lat - 1));
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: bus transfer observed mid-cycle, committed just after the edge.
  task automatic tick();
    logic rq, fire, wr;
    logic [7:0] a;
    logic [15:0] wd;
    @(negedge clk);
    rq   = bus.mem_req;
    fire = bus.mem_req && bus.mem_ack;
    wr   = fire && bus.mem_we;
    a    = bus.mem_addr[7:0];
    wd   = bus.mem_wdata;
    @(posedge clk);
    #1;
    if (wr) mem[a] = wd;
    if (fire || !rq) wcnt = 0;
    else wcnt++;
    if (out_valid) ov_cnt++;
  endtask

  task automatic fill();
    for (int i = 0; i < 256; i++) mem[i] = 16'h00FF;
  endtask

  task automatic put(input int a, input logic [15:0] o, input logic [15:0] x, input logic [15:0] y);
    mem[a] = o;
    mem[a+1] = x;
    mem[a+2] = y;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [15:0] target, input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      ok = (dut.pc == target);
    end
  endtask

  task automatic wait_halt(input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      ok = halted;
    end
  endtask

  task automatic measure_mov2(input int l, input int expc, input string name);
    int n;
    logic seen;
    lat = l;
    fill();
    put(0, MOV2, 0, 16'h1234);
    put(3, JMP, 3, 0);
    do_reset();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = bus.mem_req;
    end
    check({name, "_req_seen"}, seen, 1);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (dut.regs[0] == 16'h1234) begin
        n = k;
        break;
      end
    end
    check(name, n, expc);
  endtask

  typedef struct packed {
    logic [15:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] y;
    logic [2:0]  fl;   // {of, zf, cf}
    logic [2:0]  msk;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  logic ok;

  initial begin
    vecs[0]  = '{16'h0C, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 3'b011, 3'b111};
    vecs[1]  = '{16'h0C, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 3'b100, 3'b111};
    vecs[2]  = '{16'h0D, 16'h0001, 16'h0001, 1'b1, 16'h0003, 3'b000, 3'b111};
    vecs[3]  = '{16'h0E, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 3'b001, 3'b111};
    vecs[4]  = '{16'h0F, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 3'b001, 3'b111};
    vecs[5]  = '{16'h14, 16'h1234, 16'h1234, 1'b0, 16'h1234, 3'b010, 3'b111};
    vecs[6]  = '{16'h0E, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 3'b100, 3'b111};
    vecs[7]  = '{16'h15, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 3'b000, 3'b111};
    vecs[8]  = '{16'h18, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 3'b000, 3'b111};
    vecs[9]  = '{16'h1B, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 3'b010, 3'b111};
    vecs[10] = '{16'h1C, 16'h00FF, 16'hFF00, 1'b1, 16'h00FF, 3'b010, 3'b111};
    vecs[11] = '{16'h17, 16'h00FF, 16'h0000, 1'b1, 16'hFF00, 3'b000, 3'b111};
    vecs[12] = '{16'h16, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 3'b001, 3'b111};
    vecs[13] = '{16'h16, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b010, 3'b111};
    vecs[14] = '{16'h16, 16'h8000, 16'h0000, 1'b0, 16'h8000, 3'b101, 3'b111};
    vecs[15] = '{16'h19, 16'h8001, 16'h0000, 1'b0, 16'h0002, 3'b001, 3'b011};
    vecs[16] = '{16'h1A, 16'h0001, 16'h0000, 1'b0, 16'h0000, 3'b011, 3'b011};
    vecs[17] = '{16'h0C, 16'h0001, 16'h0001, 1'b1, 16'h0002, 3'b000, 3'b111};

    // reset state
    fill();
    do_reset();
    check("rst_pc", dut.pc, 0);
    check("rst_sp", dut.sp, 0);
    check("rst_flags", dut.flags, 0);
    check("rst_state", dut.state == F_OP, 1);
    check("rst_req", bus.mem_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_base_data", {base, data}, 0);
    check("rst_halted", halted, 0);

    measure_mov2(1, 4, "lat1_cycles");
    measure_mov2(3, 10, "lat3_cycles");

    lat = 1;
    for (int i = 0; i < NV; i++) begin
      fill();
      put(0, MOV2, 0, vecs[i].a);
      put(3, MOV2, 1, vecs[i].b);
      put(6, vecs[i].cin ? SCF : CCF, 0, 0);
      put(9, vecs[i].op, 0, 1);
      put(12, JMP, 12, 0);
      do_reset();
      wait_pc(16'd12, 120, ok);
      check($sformatf("alu%0d_done", i), ok, 1);
      check($sformatf("alu%0d_y", i), dut.regs[0], vecs[i].y);
      check($sformatf("alu%0d_flags", i),
            {dut.flags[FLAG_OF], dut.flags[FLAG_ZF], dut.flags[FLAG_CF]} & vecs[i].msk,
            vecs[i].fl & vecs[i].msk);
    end

    // call/return and conditional branches
    fill();
    put(16'h00, JMP, 16'h10, 0);
    put(16'h10, CALL, 16'h40, 0);
    put(16'h40, RET, 0, 0);
    put(16'h13, CMP, 0, 0);
    put(16'h16, JZ, 16'h30, 0);
    put(16'h30, JNZ, 16'h50, 0);
    put(16'h33, JC, 16'h60, 0);
    put(16'h36, JMP, 16'h36, 0);
    do_reset();
    wait_pc(16'h40, 60, ok);
    check("call_reached", ok, 1);
    check("call_sp", dut.sp, 1);
    check("call_stack_top", dut.stack[0], 16'h13);
    wait_pc(16'h13, 60, ok);
    check("ret_reached", ok, 1);
    check("ret_sp", dut.sp, 0);
    wait_pc(16'h36, 80, ok);
    check("branch_path", ok, 1);
    for (int k = 0; k < 10; k++) tick();
    check("branch_loop_pc", dut.pc, 16'h36);
    check("branch_not_halted", halted, 0);

    // stack overflow on the 17th PUSH
    fill();
    put(0, MOV2, 0, 16'h0ABC);
    for (int k = 0; k < 17; k++) put(3 + 3*k, PUSH, 0, 0);
    do_reset();
    wait_halt(400, ok);
    check("ovf_halted", ok, 1);
    check("ovf_pc", dut.pc, 16'h33);
    check("ovf_sp", dut.sp, 16);
    check("ovf_stack_last", dut.stack[15], 16'h0ABC);
    tick();
    check("ovf_req_low", bus.mem_req, 0);

    // stack underflow
    fill();
    put(0, POP, 0, 0);
    do_reset();
    wait_halt(30, ok);
    check("udf_halted", ok, 1);
    check("udf_pc_sp", {dut.pc, 11'd0, dut.sp}, 0);

    // IO and data memory with wait states
    lat = 2;
    fill();
    in_port = 16'hBEEF;
    mem[16'h20] = 16'h0000;
    put(0, IN, 2, 0);
    put(3, OUT, 5, 2);
    put(6, MOV4, 16'h20, 2);
    put(9, MOV3, 3, 16'h20);
    put(12, MOV1, 1, 2);
    put(15, MOV2, 0, 7);
    put(18, XCH, 0, 1);
    put(21, JMP, 21, 0);
    do_reset();
    ov_cnt = 0;
    wait_pc(16'd21, 300, ok);
    check("io_done", ok, 1);
    check("io_base", base, 16'h5);
    check("io_data", data, 16'hBEEF);
    check("io_strobe_count", ov_cnt, 1);
    check("mov4_mem", mem[16'h20], 16'hBEEF);
    check("mov3_r3", dut.regs[3], 16'hBEEF);
    check("xch_r0", dut.regs[0], 16'hBEEF);
    check("xch_r1", dut.regs[1], 16'h0007);

    // reset mid-fetch, late ack ignored, then undefined opcode
    lat = 3;
    in_port = '0;
    fill();
    mem[0] = 16'h0077;
    do_reset();
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      tick();
      ok = bus.mem_req;
    end
    check("midrst_req_seen", ok, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_req_dropped", bus.mem_req, 0);
    check("midrst_pc", dut.pc, 0);
    rst_n = 1'b1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("late_ack_ignored", dut.state == F_OP, 1);
    wait_halt(40, ok);
    check("undef_halted", ok, 1);
    check("undef_pc", dut.pc, 0);

    // register field out of range
    lat = 1;
    fill();
    put(0, MOV2, 4, 1);
    do_reset();
    wait_halt(30, ok);
    check("regfield_halted", ok, 1);
    check("regfield_r0", dut.regs[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
